// File: rtl/jk_bank_driver.sv
// Loads an external bank of WIDTH JK flip-flops with a target word: pulses J/K, waits, verifies readback, retries.
// Optional macro JK_TOGGLE_EN: drive mismatching bits with the toggle code (j=k=1) instead of set/reset.
module jk_bank_driver #(
    parameter int WIDTH     = 4,
    parameter int SETTLE    = 1,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    state_t           state;
    logic [WIDTH-1:0] target;
    logic [2:0]       retry_cnt;
    logic [3:0]       settle_cnt;

    // Returns {j, k} that move the bank from q to t in one clock.
    function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] t);
`ifdef JK_TOGGLE_EN
        return {q ^ t, q ^ t};
`else
        return {~q & t, q & ~t};
`endif
    endfunction

    // NOTE: every register here is assigned with <= so all updates in this block
    // see the pre-edge values; mixing in = would make results depend on statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            target     <= '0;
            retry_cnt  <= '0;
            settle_cnt <= '0;
            j          <= '0;
            k          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            tgt_ready  <= 1'b1;
        end else begin
            // J/K, done and err are single-cycle pulses unless a branch below sets them.
            j    <= '0;
            k    <= '0;
            done <= 1'b0;
            err  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (tgt_valid && tgt_ready) begin
                        target    <= tgt_data;
                        retry_cnt <= '0;
                        {j, k}    <= excite(q_fb, tgt_data);
                        state     <= ST_DRIVE;
                        busy      <= 1'b1;
                        tgt_ready <= 1'b0;
                    end
                end

                ST_DRIVE: begin
                    settle_cnt <= SETTLE_LAST;
                    state      <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (settle_cnt == 4'd0) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                ST_CHECK: begin
                    if (q_fb == target) begin
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        tgt_ready <= 1'b1;
                    end else if (retry_cnt != RETRY_LIMIT) begin
                        // Recompute from the bank's present state, not the original one.
                        retry_cnt <= retry_cnt + 3'd1;
                        {j, k}    <= excite(q_fb, target);
                        state     <= ST_DRIVE;
                    end else begin
                        err       <= 1'b1;
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        tgt_ready <= 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    tgt_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
